// File: rtl/exec_ctrl_seq.sv
// exec_ctrl_seq: execute-stage controller with internal N/Z flags, memory stall/timeout and post-jump flush.
module exec_ctrl_seq #(
  parameter int OPW          = 5,
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [OPW-1:0] instr,
  input  logic           alu_n,
  input  logic           alu_z,
  input  logic           mem_ready,
  output logic [1:0]     sel_alu_a,
  output logic [1:0]     sel_alu_b,
  output logic           addsub,
  output logic           ld_alu_r,
  output logic           ld_nz,
  output logic           ld_pc_ac,
  output logic           ld_ir_ac,
  output logic           o_ldst_rd,
  output logic           o_ldst_wr,
  output logic           r_jump,
  output logic           s_jump,
  output logic           stall,
  output logic           flush,
  output logic           mem_err,
  output logic           illegal_op
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int FW = FLUSH_CYCLES > 0 ? $clog2(FLUSH_CYCLES + 1) : 1;
  typedef enum logic [1:0] {RUN, MEM, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [1:0]    nz_q;
  logic [WW-1:0] wait_q, wait_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          st_q, st_d;
  logic [4:0]    op;
  logic          is_alu, is_mem, is_jmp, legal, cond, taken;
  assign op     = instr[4:0];
  assign is_alu = op inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h10, 5'h11, 5'h12, 5'h13, 5'h16};
  assign is_mem = op inside {5'h04, 5'h05};
  assign is_jmp = op inside {5'h08, 5'h09, 5'h0A, 5'h0C, 5'h18, 5'h19, 5'h1A, 5'h1C};
  assign legal  = ((instr >> 5) == '0) && (is_alu || is_mem || is_jmp);
  // nz_q is {n, z}; bit 1 of the opcode selects N, bit 0 selects Z, neither means unconditional
  assign cond   = op[1] ? nz_q[1] : op[0] ? nz_q[0] : 1'b1;
  assign taken  = is_jmp && cond;
  always_comb begin
    sel_alu_a  = 2'd0;
    sel_alu_b  = 2'd0;
    addsub     = 1'b0;
    ld_alu_r   = 1'b0;
    ld_nz      = 1'b0;
    ld_pc_ac   = 1'b0;
    ld_ir_ac   = 1'b0;
    o_ldst_rd  = 1'b0;
    o_ldst_wr  = 1'b0;
    r_jump     = 1'b0;
    s_jump     = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    mem_err    = 1'b0;
    illegal_op = 1'b0;
    state_d    = state_q;
    wait_d     = wait_q;
    flush_d    = flush_q;
    st_d       = st_q;
    if (!reset) begin
      case (state_q)
        RUN: begin
          ld_pc_ac   = 1'b1;
          ld_ir_ac   = 1'b1;
          illegal_op = in_valid && !legal;
          if (in_valid && legal && is_alu) begin
            ld_alu_r  = 1'b1;
            ld_nz     = 1'b1;
            sel_alu_a = (op[1:0] == 2'b00 || op[2]) ? 2'd1 : 2'd0;
            sel_alu_b = op[2] ? 2'd2 : {1'b0, op[4]};
            addsub    = op[1] && !op[2];
          end
          if (in_valid && legal && is_mem) begin
            o_ldst_rd = !op[0];
            o_ldst_wr = op[0];
            stall     = !mem_ready;
            ld_pc_ac  = mem_ready;
            ld_ir_ac  = mem_ready;
            st_d      = op[0];
            wait_d    = '0;
            state_d   = mem_ready ? RUN : MEM;
          end
          if (in_valid && legal && is_jmp) begin
            ld_alu_r = 1'b1;
            r_jump   = !op[4] && cond;
            s_jump   = op[4] && cond;
            if (taken && FLUSH_CYCLES > 0) begin
              state_d = FLUSH;
              flush_d = FW'(FLUSH_CYCLES);
            end
          end
        end
        MEM: begin
          wait_d = wait_q + WW'(1);
          if (mem_ready) begin
            o_ldst_rd = !st_q;
            o_ldst_wr = st_q;
            ld_pc_ac  = 1'b1;
            ld_ir_ac  = 1'b1;
            state_d   = RUN;
          end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
            mem_err  = 1'b1;
            ld_pc_ac = 1'b1;
            ld_ir_ac = 1'b1;
            state_d  = RUN;
          end else begin
            o_ldst_rd = !st_q;
            o_ldst_wr = st_q;
            stall     = 1'b1;
          end
        end
        FLUSH: begin
          flush    = 1'b1;
          ld_pc_ac = 1'b1;
          ld_ir_ac = 1'b1;
          flush_d  = flush_q - FW'(1);
          state_d  = flush_q <= FW'(1) ? RUN : FLUSH;
        end
        default: state_d = RUN;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      nz_q    <= 2'b00;
      wait_q  <= '0;
      flush_q <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      flush_q <= flush_d;
      st_q    <= st_d;
      if (ld_nz) nz_q <= {alu_n, alu_z};
    end
  end
endmodule

// File: tb/tb_exec_ctrl_seq.sv
// tb_exec_ctrl_seq: directed checks of decode, flags, memory wait/timeout, flush, reset and illegal opcodes.
module tb_exec_ctrl_seq;
  logic clk = 1'b0;
  logic reset, in_valid, alu_n, alu_z, mem_ready;
  logic [5:0] instr;
  logic [1:0] sel_alu_a, sel_alu_b;
  logic addsub, ld_alu_r, ld_nz, ld_pc_ac, ld_ir_ac, o_ldst_rd, o_ldst_wr;
  logic r_jump, s_jump, stall, flush, mem_err, illegal_op;
  logic [16:0] outs;
  int checks = 0;
  int failures = 0;

  localparam logic [16:0] A1 = 17'h08000, B1 = 17'h02000, B2 = 17'h04000, SUB = 17'h01000;
  localparam logic [16:0] ALUR = 17'h00800, NZ = 17'h00400, PCIR = 17'h00300;
  localparam logic [16:0] RD = 17'h00080, WR = 17'h00040, RJ = 17'h00020, SJ = 17'h00010;
  localparam logic [16:0] STL = 17'h00008, FL = 17'h00004, ME = 17'h00002, ILL = 17'h00001;
  localparam logic [16:0] ALU = ALUR | NZ | PCIR;

  exec_ctrl_seq #(.OPW(6), .MEM_TIMEOUT(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .alu_n(alu_n), .alu_z(alu_z), .mem_ready(mem_ready),
    .sel_alu_a(sel_alu_a), .sel_alu_b(sel_alu_b), .addsub(addsub),
    .ld_alu_r(ld_alu_r), .ld_nz(ld_nz), .ld_pc_ac(ld_pc_ac), .ld_ir_ac(ld_ir_ac),
    .o_ldst_rd(o_ldst_rd), .o_ldst_wr(o_ldst_wr), .r_jump(r_jump), .s_jump(s_jump),
    .stall(stall), .flush(flush), .mem_err(mem_err), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  assign outs = {sel_alu_a, sel_alu_b, addsub, ld_alu_r, ld_nz, ld_pc_ac, ld_ir_ac,
                 o_ldst_rd, o_ldst_wr, r_jump, s_jump, stall, flush, mem_err, illegal_op};

  function automatic logic [9:0] sv(input logic v, input logic [5:0] op, input logic n, input logic z, input logic r);
    return {v, op, n, z, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    {in_valid, instr, alu_n, alu_z, mem_ready} = sv(1, 6'h01, 1, 1, 1);
    #1;
    checks++;
    if (outs !== 17'h0) begin failures++; $display("FAIL reset_hold got=%h exp=%h", outs, 17'h0); end
    tick;
    checks++;
    if (outs !== 17'h0) begin failures++; $display("FAIL reset_edge got=%h exp=%h", outs, 17'h0); end
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== ALU) begin failures++; $display("FAIL reset_release got=%h exp=%h", outs, ALU); end
    tick;
  endtask

  task automatic test_alu_decode;
    logic [9:0] s [10];
    logic [16:0] e [10];
    s = '{sv(1, 6'h00, 0, 0, 0), sv(1, 6'h01, 0, 0, 0), sv(1, 6'h02, 0, 0, 0), sv(1, 6'h03, 0, 0, 0),
          sv(1, 6'h10, 0, 0, 0), sv(1, 6'h11, 0, 0, 0), sv(1, 6'h12, 0, 0, 0), sv(1, 6'h13, 0, 0, 0),
          sv(1, 6'h16, 0, 0, 0), sv(0, 6'h01, 0, 0, 0)};
    e = '{A1 | ALU, ALU, SUB | ALU, SUB | ALU, A1 | B1 | ALU, B1 | ALU, SUB | B1 | ALU,
          SUB | B1 | ALU, A1 | B2 | ALU, PCIR};
    for (int i = 0; i < 10; i++) begin
      {in_valid, instr, alu_n, alu_z, mem_ready} = s[i];
      #1;
      checks++;
      if (outs !== e[i]) begin failures++; $display("FAIL alu_decode[%0d] got=%h exp=%h", i, outs, e[i]); end
      tick;
    end
  endtask

  task automatic test_flag_path;
    logic [9:0] s [9];
    logic [16:0] e [9];
    s = '{sv(1, 6'h03, 0, 1, 0), sv(1, 6'h19, 0, 0, 0), sv(1, 6'h01, 0, 0, 0), sv(1, 6'h01, 0, 0, 0),
          sv(1, 6'h01, 0, 0, 0), sv(1, 6'h03, 1, 0, 0), sv(1, 6'h1A, 0, 0, 0), sv(1, 6'h01, 0, 0, 0),
          sv(1, 6'h01, 0, 0, 0)};
    e = '{SUB | ALU, SJ | ALUR | PCIR, FL | PCIR, FL | PCIR, ALU, SUB | ALU, SJ | ALUR | PCIR,
          FL | PCIR, FL | PCIR};
    for (int i = 0; i < 9; i++) begin
      {in_valid, instr, alu_n, alu_z, mem_ready} = s[i];
      #1;
      checks++;
      if (outs !== e[i]) begin failures++; $display("FAIL flag_path[%0d] got=%h exp=%h", i, outs, e[i]); end
      tick;
    end
  endtask

  task automatic test_stale_flags;
    logic [9:0] s [8];
    logic [16:0] e [8];
    s = '{sv(1, 6'h03, 0, 0, 0), sv(1, 6'h0A, 1, 1, 0), sv(1, 6'h09, 0, 0, 0), sv(1, 6'h01, 0, 1, 0),
          sv(1, 6'h09, 0, 0, 0), sv(1, 6'h01, 0, 0, 0), sv(1, 6'h01, 0, 0, 0), sv(1, 6'h0C, 0, 0, 0)};
    e = '{SUB | ALU, ALUR | PCIR, ALUR | PCIR, ALU, RJ | ALUR | PCIR, FL | PCIR, FL | PCIR,
          RJ | ALUR | PCIR};
    for (int i = 0; i < 8; i++) begin
      {in_valid, instr, alu_n, alu_z, mem_ready} = s[i];
      #1;
      checks++;
      if (outs !== e[i]) begin failures++; $display("FAIL stale_flags[%0d] got=%h exp=%h", i, outs, e[i]); end
      tick;
    end
    repeat (2) tick;
  endtask

  task automatic test_mem_wait;
    logic [9:0] s [7];
    logic [16:0] e [7];
    s = '{sv(1, 6'h04, 0, 0, 0), sv(1, 6'h04, 0, 0, 0), sv(1, 6'h04, 0, 0, 0), sv(1, 6'h04, 0, 0, 1),
          sv(1, 6'h01, 0, 0, 0), sv(1, 6'h04, 0, 0, 1), sv(1, 6'h01, 0, 0, 0)};
    e = '{RD | STL, RD | STL, RD | STL, RD | PCIR, ALU, RD | PCIR, ALU};
    for (int i = 0; i < 7; i++) begin
      {in_valid, instr, alu_n, alu_z, mem_ready} = s[i];
      #1;
      checks++;
      if (outs !== e[i]) begin failures++; $display("FAIL mem_wait[%0d] got=%h exp=%h", i, outs, e[i]); end
      tick;
    end
  endtask

  task automatic test_mem_timeout;
    logic [9:0] s [12];
    logic [16:0] e [12];
    s = '{sv(1, 6'h05, 0, 0, 0), sv(1, 6'h05, 0, 0, 0), sv(1, 6'h05, 0, 0, 0), sv(1, 6'h05, 0, 0, 0),
          sv(1, 6'h05, 0, 0, 0), sv(1, 6'h01, 0, 0, 0),
          sv(1, 6'h05, 0, 0, 0), sv(1, 6'h05, 0, 0, 0), sv(1, 6'h05, 0, 0, 0), sv(1, 6'h05, 0, 0, 0),
          sv(1, 6'h05, 0, 0, 1), sv(1, 6'h01, 0, 0, 0)};
    e = '{WR | STL, WR | STL, WR | STL, WR | STL, ME | PCIR, ALU,
          WR | STL, WR | STL, WR | STL, WR | STL, WR | PCIR, ALU};
    for (int i = 0; i < 12; i++) begin
      {in_valid, instr, alu_n, alu_z, mem_ready} = s[i];
      #1;
      checks++;
      if (outs !== e[i]) begin failures++; $display("FAIL mem_timeout[%0d] got=%h exp=%h", i, outs, e[i]); end
      tick;
    end
  endtask

  task automatic test_flush_length;
    logic [9:0] s [6];
    logic [16:0] e [6];
    s = '{sv(1, 6'h01, 0, 0, 0), sv(1, 6'h18, 0, 0, 0), sv(1, 6'h01, 1, 1, 0), sv(1, 6'h01, 1, 1, 0),
          sv(1, 6'h19, 0, 0, 0), sv(1, 6'h01, 0, 0, 0)};
    e = '{ALU, SJ | ALUR | PCIR, FL | PCIR, FL | PCIR, ALUR | PCIR, ALU};
    for (int i = 0; i < 6; i++) begin
      {in_valid, instr, alu_n, alu_z, mem_ready} = s[i];
      #1;
      checks++;
      if (outs !== e[i]) begin failures++; $display("FAIL flush_length[%0d] got=%h exp=%h", i, outs, e[i]); end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    {in_valid, instr, alu_n, alu_z, mem_ready} = sv(1, 6'h03, 0, 1, 0);
    #1;
    checks++;
    if (outs !== (SUB | ALU)) begin failures++; $display("FAIL rst_mid_cmp got=%h exp=%h", outs, SUB | ALU); end
    tick;
    {in_valid, instr, alu_n, alu_z, mem_ready} = sv(1, 6'h04, 0, 0, 0);
    #1;
    checks++;
    if (outs !== (RD | STL)) begin failures++; $display("FAIL rst_mid_ld got=%h exp=%h", outs, RD | STL); end
    tick;
    #1;
    checks++;
    if (outs !== (RD | STL)) begin failures++; $display("FAIL rst_mid_mem got=%h exp=%h", outs, RD | STL); end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== 17'h0) begin failures++; $display("FAIL rst_mid_async got=%h exp=%h", outs, 17'h0); end
    tick;
    checks++;
    if (outs !== 17'h0) begin failures++; $display("FAIL rst_mid_held got=%h exp=%h", outs, 17'h0); end
    reset = 1'b0;
    {in_valid, instr, alu_n, alu_z, mem_ready} = sv(0, 6'h04, 0, 0, 0);
    #1;
    checks++;
    if (outs !== PCIR) begin failures++; $display("FAIL rst_mid_release got=%h exp=%h", outs, PCIR); end
    tick;
    {in_valid, instr, alu_n, alu_z, mem_ready} = sv(1, 6'h19, 0, 0, 0);
    #1;
    checks++;
    if (outs !== (ALUR | PCIR)) begin failures++; $display("FAIL rst_mid_nz_clear got=%h exp=%h", outs, ALUR | PCIR); end
    tick;
    {in_valid, instr, alu_n, alu_z, mem_ready} = sv(1, 6'h18, 0, 0, 0);
    #1;
    checks++;
    if (outs !== (SJ | ALUR | PCIR)) begin failures++; $display("FAIL rst_flush_j got=%h exp=%h", outs, SJ | ALUR | PCIR); end
    tick;
    {in_valid, instr, alu_n, alu_z, mem_ready} = sv(1, 6'h01, 0, 0, 0);
    #1;
    checks++;
    if (outs !== (FL | PCIR)) begin failures++; $display("FAIL rst_flush_in got=%h exp=%h", outs, FL | PCIR); end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== 17'h0) begin failures++; $display("FAIL rst_flush_async got=%h exp=%h", outs, 17'h0); end
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== ALU) begin failures++; $display("FAIL rst_flush_release got=%h exp=%h", outs, ALU); end
    tick;
  endtask

  task automatic test_illegal;
    logic [9:0] s [7];
    logic [16:0] e [7];
    s = '{sv(1, 6'h21, 0, 0, 1), sv(1, 6'h06, 0, 0, 1), sv(1, 6'h0B, 0, 0, 1), sv(1, 6'h1F, 0, 0, 1),
          sv(1, 6'h24, 0, 0, 0), sv(0, 6'h21, 0, 0, 0), sv(1, 6'h01, 0, 0, 0)};
    e = '{ILL | PCIR, ILL | PCIR, ILL | PCIR, ILL | PCIR, ILL | PCIR, PCIR, ALU};
    for (int i = 0; i < 7; i++) begin
      {in_valid, instr, alu_n, alu_z, mem_ready} = s[i];
      #1;
      checks++;
      if (outs !== e[i]) begin failures++; $display("FAIL illegal[%0d] got=%h exp=%h", i, outs, e[i]); end
      tick;
    end
  endtask

  initial begin
    reset = 1'b1;
    {in_valid, instr, alu_n, alu_z, mem_ready} = '0;
    tick;
    test_reset;
    test_alu_decode;
    test_flag_path;
    test_stale_flags;
    test_mem_wait;
    test_mem_timeout;
    test_flush_length;
    test_reset_mid;
    test_illegal;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
